// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request, datapath and result signals of the multiply sequencer
interface mul_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        flush;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_signed;
  logic [62:0] mul_c;
  logic [63:0] mul_s;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        busy;
  modport slave (
    input  req_valid, req_signed, req_x, req_y, flush, mul_c, mul_s, res_ready,
    output req_ready, mul_x, mul_y, mul_signed, res_valid, res_hi, res_lo, busy
  );
  modport master (
    output req_valid, req_signed, req_x, req_y, flush, mul_c, mul_s, res_ready,
    input  req_ready, mul_x, mul_y, mul_signed, res_valid, res_hi, res_lo, busy
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences one MULT/MULTU through the Booth/Wallace datapath and final carry-propagate add
module mul_seq_ctrl #(
  parameter bit ADD_SPLIT = 1'b0
) (
  input logic           clk,
  input logic           resetn,
  mul_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CSA, ADD, ADD_LO, ADD_HI, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] x_r, y_r, hi_r, lo_r;
  logic        sg_r, carry_r, accept;
  logic [62:0] c_r;
  logic [63:0] s_r, full_sum;
  logic [32:0] lo_sum;
  logic [31:0] hi_sum;
  assign bus.req_ready  = !bus.flush && (state == IDLE || (state == DONE && bus.res_ready));
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.res_valid  = state == DONE;
  assign bus.busy       = state != IDLE;
  assign bus.mul_x      = x_r;
  assign bus.mul_y      = y_r;
  assign bus.mul_signed = sg_r;
  assign bus.res_hi     = hi_r;
  assign bus.res_lo     = lo_r;
  // the carry vector is pre-shifted left by one relative to the sum vector
  assign full_sum = s_r + {c_r, 1'b0};
  assign lo_sum   = {1'b0, s_r[31:0]} + {1'b0, c_r[30:0], 1'b0};
  assign hi_sum   = s_r[63:32] + c_r[62:31] + {31'b0, carry_r};
  // next state; flush overrides accept and the result handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = accept ? CSA : IDLE;
      CSA:         state_nx = ADD_SPLIT ? ADD_LO : ADD;
      ADD, ADD_HI: state_nx = DONE;
      ADD_LO:      state_nx = ADD_HI;
      DONE:        state_nx = accept ? CSA : (bus.res_ready ? IDLE : DONE);
      default:     state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // operand capture; held so the datapath sees stable inputs through CSA
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x_r  <= '0;
      y_r  <= '0;
      sg_r <= 1'b0;
    end else if (accept) begin
      x_r  <= bus.req_x;
      y_r  <= bus.req_y;
      sg_r <= bus.req_signed;
    end
  // capture compressor carry/sum at the end of CSA
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      c_r <= '0;
      s_r <= '0;
    end else if (state == CSA) begin
      c_r <= bus.mul_c;
      s_r <= bus.mul_s;
    end
  // final add; a flushed operation leaves the previous result untouched
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hi_r    <= '0;
      lo_r    <= '0;
      carry_r <= 1'b0;
    end else if (!bus.flush) begin
      if (state == ADD) {hi_r, lo_r} <= full_sum;
      if (state == ADD_LO) {carry_r, lo_r} <= lo_sum;
      if (state == ADD_HI) hi_r <= hi_sum;
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: checks both final-add variants with a carry/sum datapath model and a result scoreboard
module tb_mul_seq_ctrl;
  typedef struct {
    logic [31:0] x, y;
    logic        sg;
    logic [31:0] hi, lo;
  } vec_t;
  logic        clk = 1'b0, resetn = 1'b1, sel = 1'b0;
  logic        req_valid = 1'b0, req_signed = 1'b0, flush = 1'b0, res_ready = 1'b1;
  logic [31:0] req_x = '0, req_y = '0;
  logic [62:0] c_rand = '0;
  logic        req_ready, res_valid, busy, mul_signed;
  logic [31:0] res_hi, res_lo, mul_x, mul_y;
  int          checks = 0, passes = 0;
  logic [63:0] sbq[$];
  vec_t        vecs[8];
  mul_seq_ctrl_if u_if0 ();
  mul_seq_ctrl_if u_if1 ();
  mul_seq_ctrl #(.ADD_SPLIT(1'b0)) u_dut0 (.clk(clk), .resetn(resetn), .bus(u_if0.slave));
  mul_seq_ctrl #(.ADD_SPLIT(1'b1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(u_if1.slave));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic sg);
    logic [63:0] a, b;
    a = {{32{sg & x[31]}}, x};
    b = {{32{sg & y[31]}}, y};
    return a * b;
  endfunction
  assign u_if0.req_valid  = req_valid & ~sel;
  assign u_if1.req_valid  = req_valid & sel;
  assign u_if0.flush      = flush & ~sel;
  assign u_if1.flush      = flush & sel;
  assign u_if0.req_signed = req_signed;
  assign u_if1.req_signed = req_signed;
  assign u_if0.req_x      = req_x;
  assign u_if1.req_x      = req_x;
  assign u_if0.req_y      = req_y;
  assign u_if1.req_y      = req_y;
  assign u_if0.res_ready  = res_ready;
  assign u_if1.res_ready  = res_ready;
  assign u_if0.mul_c      = c_rand;
  assign u_if1.mul_c      = c_rand;
  assign u_if0.mul_s      = ref_mul(u_if0.mul_x, u_if0.mul_y, u_if0.mul_signed) - {c_rand, 1'b0};
  assign u_if1.mul_s      = ref_mul(u_if1.mul_x, u_if1.mul_y, u_if1.mul_signed) - {c_rand, 1'b0};
  assign req_ready  = sel ? u_if1.req_ready : u_if0.req_ready;
  assign res_valid  = sel ? u_if1.res_valid : u_if0.res_valid;
  assign busy       = sel ? u_if1.busy : u_if0.busy;
  assign res_hi     = sel ? u_if1.res_hi : u_if0.res_hi;
  assign res_lo     = sel ? u_if1.res_lo : u_if0.res_lo;
  assign mul_x      = sel ? u_if1.mul_x : u_if0.mul_x;
  assign mul_y      = sel ? u_if1.mul_y : u_if0.mul_y;
  assign mul_signed = sel ? u_if1.mul_signed : u_if0.mul_signed;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (add_split=%0d)", name, act, exp, sel);
  endtask
  // scoreboard: push on accept, pop on delivered result; flush and reset drop in-flight work
  always @(negedge clk) begin
    if (!resetn || flush) sbq.delete();
    else begin
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) check("sb_unexpected", {63'b0, res_valid}, 64'd0);
        else check("sb_result", {res_hi, res_lo}, sbq.pop_front());
      end
      if (req_valid && req_ready) sbq.push_back(ref_mul(req_x, req_y, req_signed));
    end
  end
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic sg);
    int n = 0;
    req_x = x;
    req_y = y;
    req_signed = sg;
    req_valid = 1'b1;
    c_rand = 63'({$urandom, $urandom});
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic sg,
                        input logic [31:0] hi, input logic [31:0] lo);
    int lat;
    start_op(x, y, sg);
    wait_valid(lat);
    check({name, "_latency"}, 64'(lat), 64'(sel ? 3 : 2));
    check({name, "_hi"}, {32'b0, res_hi}, {32'b0, hi});
    check({name, "_lo"}, {32'b0, res_lo}, {32'b0, lo});
    @(posedge clk);
    #1;
  endtask
  task automatic flush_at(input string name, input int mode);
    int lat;
    res_ready = (mode != 2);
    start_op(32'h0000_1234, 32'h0000_5678, 1'b0);
    if (mode == 1) begin
      @(posedge clk);
      #1;
    end
    if (mode == 2) begin
      wait_valid(lat);
      check({name, "_valid_before"}, {63'b0, res_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    res_ready = 1'b1;
    check({name, "_busy"}, {63'b0, busy}, 64'd0);
    check({name, "_valid"}, {63'b0, res_valid}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      check({name, "_no_result"}, {63'b0, res_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0B00_EA4E, 32'h242D_2080};
    vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[5] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[7] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F};
    #1 resetn = 1'b0;
    #2;
    check("rst_res_valid", {63'b0, res_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_mul_x", {32'b0, mul_x}, 64'd0);
    check("rst_mul_y", {32'b0, mul_y}, 64'd0);
    check("rst_mul_signed", {63'b0, mul_signed}, 64'd0);
    check("rst_res_hi", {32'b0, res_hi}, 64'd0);
    check("rst_res_lo", {32'b0, res_lo}, 64'd0);
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 8; i++)
        run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sg, vecs[i].hi, vecs[i].lo);
      for (int i = 0; i < 1000; i++)
        run_op("carry_stress", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0B00_EA4E, 32'h242D_2080);
      res_ready = 1'b0;
      start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      wait_valid(lat);
      check("bp_latency", 64'(lat), 64'(sel ? 3 : 2));
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        check("bp_res_valid", {63'b0, res_valid}, 64'd1);
        check("bp_hold", {res_hi, res_lo}, 64'h0B00_EA4E_242D_2080);
        check("bp_req_ready", {63'b0, req_ready}, 64'd0);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      req_valid = 1'b1;
      req_x = 32'hFFFF_FFFF;
      req_y = 32'hFFFF_FFFF;
      req_signed = 1'b1;
      c_rand = 63'({$urandom, $urandom});
      @(negedge clk);
      check("b2b_req_ready", {63'b0, req_ready}, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("b2b_busy", {63'b0, busy}, 64'd1);
      check("b2b_res_valid", {63'b0, res_valid}, 64'd0);
      wait_valid(lat);
      check("b2b_latency", 64'(lat), 64'(sel ? 3 : 2));
      check("b2b_result", {res_hi, res_lo}, 64'h0000_0000_0000_0001);
      @(posedge clk);
      #1;
      flush_at("flush_csa", 0);
      flush_at("flush_add", 1);
      flush_at("flush_done", 2);
      req_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_idle_req_ready", {63'b0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("flush_idle_busy", {63'b0, busy}, 64'd0);
      req_valid = 1'b0;
      flush = 1'b0;
      start_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", {63'b0, busy}, 64'd0);
      check("arst_res_valid", {63'b0, res_valid}, 64'd0);
      check("arst_mul_x", {32'b0, mul_x}, 64'd0);
      check("arst_mul_y", {32'b0, mul_y}, 64'd0);
      check("arst_res_hi", {32'b0, res_hi}, 64'd0);
      check("arst_res_lo", {32'b0, res_lo}, 64'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      @(posedge clk);
      #1;
      run_op("after_reset", 32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0, 32'h0000_002A);
    end
    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for the 32x32 Booth/Wallace multiplier datapath used by MULT/MULTU.
- Accepts one request from EX and drives operands into the Booth encoder and partial-product compressor.
- Captures the compressor's carry/sum vectors, performs the final 64-bit carry-propagate add, and presents HI/LO to the HI/LO write logic through a valid/ready handshake.
- Supports pipeline flush on exception/eret.

Parameters:
ADD_SPLIT, 0, 0 = single-cycle 64-bit final add; 1 = two 32-bit add cycles (lo then hi) with registered carry

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  multiply request from EX
req_ready  out  1  block can accept request
req_signed  in  1  1 = MULT, 0 = MULTU
req_x  in  32  multiplicand (rs)
req_y  in  32  multiplier (rt)
flush  in  1  cancel any in-flight operation
mul_x  out  32  operand to Booth encoder
mul_y  out  32  operand to Booth encoder
mul_signed  out  1  signedness to Booth encoder (33-bit extension select)
mul_c  in  63  compressor carry vector
mul_s  in  64  compressor sum vector
res_valid  out  1  product valid
res_ready  in  1  HI/LO writer accepts product
res_hi  out  32  product[63:32]
res_lo  out  32  product[31:0]
busy  out  1  state != IDLE; used by hazard unit to stall MFHI/MFLO

Behaviour:
- Reset (resetn low, async): state IDLE; operand regs, C/S regs, result regs and carry reg = 0; res_valid = 0; mul_x, mul_y, mul_signed = 0.
- States: IDLE, CSA, ADD (ADD_SPLIT=0) or ADD_LO/ADD_HI (ADD_SPLIT=1), DONE.
- req_ready = !flush && (IDLE || (DONE && res_ready)). Accept = req_valid && req_ready.
- On accept: latch req_x, req_y, req_signed into operand regs; next state CSA.
- mul_x/mul_y/mul_signed always come from the operand regs, so the datapath sees stable inputs for all of CSA.
- CSA: the datapath is combinational within this cycle. At the edge, latch mul_c into c_r and mul_s into s_r. Next state is ADD or ADD_LO.
- ADD: product = s_r + {c_r, 1'b0}, mod 2^64; latch into res_hi/res_lo. Next state DONE.
- ADD_LO: lo = s_r[31:0] + {c_r[30:0], 1'b0}; latch lo and its carry-out into carry_r. Next state ADD_HI.
- ADD_HI: hi = s_r[63:32] + c_r[62:31] + carry_r, mod 2^32. Next state DONE.
- DONE: res_valid = 1 and res_hi/res_lo are held stable until res_valid && res_ready.
  - On that handshake with no new accept: next state IDLE, res_valid drops.
  - On that handshake with a new accept in the same cycle: next state CSA (back-to-back, no bubble).
- Latency: res_valid rises 2 edges after the accept edge (ADD_SPLIT=0), or 3 edges (ADD_SPLIT=1).
- Throughput: one multiply per 3 cycles (ADD_SPLIT=0) or 4 cycles (ADD_SPLIT=1), given res_ready high.
- flush:
  - Any state: next state IDLE; res_valid = 0 the next cycle; the product is never delivered; operand regs are not cleared.
  - Flush has priority over accept and over the result handshake in the same cycle.
- res_hi/res_lo retain their last value in IDLE. Consumers must qualify them with res_valid.
- Async reset mid-operation: immediate return to reset values; no partial result is visible.
- Signedness is applied only in the datapath. The controller's final add is the same for MULT and MULTU.

Test Plan:
- MULT: x=0xFFFFFFFF, y=0xFFFFFFFF, res_ready=1 -> res_valid 2 cycles after accept; hi=0x00000000, lo=0x00000001. With ADD_SPLIT=1 -> 3 cycles, same values.
- MULTU: x=0xFFFFFFFF, y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT: x=0x80000000, y=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Carry stress: bench datapath model returns a random c with s = product - {c,0}. x=0x12345678, y=0x9ABCDEF0 unsigned -> hi=0x0B00EA4E, lo=0x242D2080, for both ADD_SPLIT values over 1000 random c.
- Backpressure and back-to-back: hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1, hi/lo stable, req_ready=0. Then raise res_ready with req_valid=1 -> same-cycle accept, state CSA, second product valid 2 cycles later.
- Flush: flush=1 in CSA, in ADD, and in DONE with res_ready=0 -> next cycle IDLE, res_valid never (or no longer) high, busy=0. Flush with req_valid=1 in IDLE -> req_ready=0, no accept.
- Reset: deassert resetn asynchronously mid-ADD_LO -> state, res_valid, mul_x, mul_y, res_hi, res_lo all 0 without a clock edge. After release, the next request completes normally.
